mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 16 +
 rtl/mem_stage_dmem_ctrl.sv | 65 ++++++
 rtl/mem_stage.sv | 123 ++++++++++++
 tb/tb_mem_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the 16-bit pipeline: data width, EX forwarding
// codes and the memory-stage access state.
package mem_stage_pkg;

  localparam int DATA_W = 16;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_stage_dmem_ctrl.sv
// Data-memory access controller: IDLE/ACCESS FSM, ack watchdog and the
// stall / request generation for the memory stage.
module dmem_ctrl
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic memop_next,
  input  logic dmem_ack,
  output logic stall,
  output logic dmem_req,
  output logic timeout,
  output logic mem_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  mem_state_t       state_q;
  mem_state_t       next_state;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // An ack arriving in the same cycle as expiry wins, so timeout excludes it.
  always_comb begin
    next_state = IDLE;
    dmem_req   = (state_q == ACCESS);
    timeout    = (state_q == ACCESS) && !dmem_ack && (cnt_q == TIMEOUT_CNT);
    stall      = (state_q == ACCESS) && !dmem_ack && !timeout;
    if (stall || memop_next) begin
      next_state = ACCESS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!stall && memop_next) begin
      cnt_q <= '0;
    end else if (stall) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_err_q <= 1'b0;
    end else if (timeout) begin
      mem_err_q <= 1'b1;
    end
  end

  assign mem_err = mem_err_q;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM and MEM/WB pipeline registers around the data-memory
// controller, plus the writeback mux and the forwarding sources for EX.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_dst,
  input  logic [DATA_W-1:0] ex_sdata,
  input  logic              ex_mem_re,
  input  logic              ex_mem_we,
  input  logic              ex_rf_we,
  input  logic [3:0]        ex_rf_dst,
  input  logic              ex_hlt,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [DATA_W-1:0] alu_result_MEM_WB,
  output logic              rf_we_MEM,
  output logic [3:0]        rf_dst_MEM,
  output logic [DATA_W-1:0] wb_data_WB,
  output logic              rf_we_WB,
  output logic [3:0]        rf_dst_WB,
  output logic              hlt_WB,
  output logic              mem_err
);

  logic              valid_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] sdata_q;
  logic              mem_re_q;
  logic              mem_we_q;
  logic              rf_we_q;
  logic [3:0]        rf_dst_q;
  logic              hlt_q;

  logic [DATA_W-1:0] wb_data_q;
  logic              rf_we_wb_q;
  logic [3:0]        rf_dst_wb_q;
  logic              hlt_wb_q;

  logic              memop_next;
  logic              timeout;
  logic [DATA_W-1:0] wb_mux;

  assign memop_next = ex_valid && (ex_mem_re || ex_mem_we);

  dmem_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_dmem_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .memop_next (memop_next),
    .dmem_ack   (dmem_ack),
    .stall      (stall),
    .dmem_req   (dmem_req),
    .timeout    (timeout),
    .mem_err    (mem_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      alu_q    <= '0;
      sdata_q  <= '0;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      rf_we_q  <= 1'b0;
      rf_dst_q <= '0;
      hlt_q    <= 1'b0;
    end else if (!stall) begin
      valid_q  <= ex_valid;
      alu_q    <= ex_dst;
      sdata_q  <= ex_sdata;
      mem_re_q <= ex_mem_re;
      mem_we_q <= ex_mem_we;
      rf_we_q  <= ex_rf_we;
      rf_dst_q <= ex_rf_dst;
      hlt_q    <= ex_hlt;
    end
  end

  assign wb_mux = (valid_q && mem_re_q) ? dmem_rdata : alu_q;

  // A stalled cycle retires a bubble; wb_data keeps its value for forwarding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data_q   <= '0;
      rf_we_wb_q  <= 1'b0;
      rf_dst_wb_q <= '0;
      hlt_wb_q    <= 1'b0;
    end else if (stall) begin
      rf_we_wb_q <= 1'b0;
      hlt_wb_q   <= 1'b0;
    end else begin
      wb_data_q   <= wb_mux;
      rf_we_wb_q  <= valid_q && rf_we_q && !mem_we_q && !timeout;
      rf_dst_wb_q <= rf_dst_q;
      hlt_wb_q    <= valid_q && hlt_q;
    end
  end

  assign dmem_we           = valid_q && mem_we_q;
  assign dmem_addr         = alu_q;
  assign dmem_wdata        = sdata_q;
  assign alu_result_MEM_WB = alu_q;
  assign rf_we_MEM         = valid_q && rf_we_q;
  assign rf_dst_MEM        = rf_dst_q;
  assign wb_data_WB        = wb_data_q;
  assign rf_we_WB          = rf_we_wb_q;
  assign rf_dst_WB         = rf_dst_wb_q;
  assign hlt_WB            = hlt_wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random traffic
// scored against an instruction-level model of retirement, stalls and errors.
module tb_mem_stage;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_mem_re, ex_mem_we, ex_rf_we, ex_hlt;
  logic [15:0] ex_dst, ex_sdata;
  logic [3:0]  ex_rf_dst;
  logic        stall, dmem_req, dmem_we, dmem_ack;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [15:0] alu_result_MEM_WB, wb_data_WB;
  logic        rf_we_MEM, rf_we_WB, hlt_WB, mem_err;
  logic [3:0]  rf_dst_MEM, rf_dst_WB;

  mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_dst(ex_dst), .ex_sdata(ex_sdata),
    .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_rf_we(ex_rf_we),
    .ex_rf_dst(ex_rf_dst), .ex_hlt(ex_hlt),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .alu_result_MEM_WB(alu_result_MEM_WB), .rf_we_MEM(rf_we_MEM),
    .rf_dst_MEM(rf_dst_MEM), .wb_data_WB(wb_data_WB), .rf_we_WB(rf_we_WB),
    .rf_dst_WB(rf_dst_WB), .hlt_WB(hlt_WB), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hlt;
    logic        rfWe;
    logic [3:0]  dst;
    logic [15:0] data;
  } retire_t;

  retire_t     expQ[$];
  int          latQ[$];
  retire_t     monEntry;
  int          checks = 0;
  int          errors = 0;
  int          obsStall = 0;
  int          expStall = 0;
  logic        expErr = 1'b0;
  logic [15:0] lastAckAddr = 16'h0;
  logic [15:0] prevAckAddr = 16'h0;
  int          latTab[7] = '{1, 1, 1, 2, 3, 5, 9};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Contents of data memory as seen by loads.
  function automatic logic [15:0] memWord(input logic [15:0] addr);
    if (addr == 16'h0040) return 16'hBEEF;
    return (addr * 16'd3) ^ 16'h1111;
  endfunction

  // Present one instruction, hold it through any stall, then log what the
  // architecture says must happen to it.
  task automatic applyStimulus(input logic valid, input logic re, input logic we,
                               input logic rfWe, input logic [3:0] rfDst,
                               input logic [15:0] dst, input logic [15:0] sdata,
                               input logic hlt, input int lat);
    logic    timedOut;
    retire_t e;
    @(negedge clk);
    ex_valid = valid; ex_mem_re = re; ex_mem_we = we; ex_rf_we = rfWe;
    ex_rf_dst = rfDst; ex_dst = dst; ex_sdata = sdata; ex_hlt = hlt;
    for (int w = 0; stall && w < TIMEOUT + 3; w++) @(negedge clk);
    if (stall) checkOutput("stallBound", stall, 1'b0);
    timedOut = 1'b0;
    if (valid && (re || we)) begin
      latQ.push_back(lat);
      expStall += (lat - 1 < TIMEOUT) ? lat - 1 : TIMEOUT;
      timedOut = (lat > TIMEOUT + 1);
      if (timedOut) expErr = 1'b1;
    end
    e.hlt  = valid && hlt;
    e.rfWe = valid && rfWe && !we && !timedOut;
    e.dst  = rfDst;
    e.data = re ? memWord(dst) : dst;
    if (e.hlt || e.rfWe) expQ.push_back(e);
    @(posedge clk);
    #1 ex_valid = 1'b0;
  endtask

  task automatic checkResetState(input string ph);
    checkOutput({ph, "Stall"}, stall, 0);
    checkOutput({ph, "Req"}, dmem_req, 0);
    checkOutput({ph, "We"}, dmem_we, 0);
    checkOutput({ph, "Addr"}, dmem_addr, 0);
    checkOutput({ph, "Wdata"}, dmem_wdata, 0);
    checkOutput({ph, "AluMem"}, alu_result_MEM_WB, 0);
    checkOutput({ph, "RfMem"}, {rf_we_MEM, rf_dst_MEM}, 0);
    checkOutput({ph, "WbData"}, wb_data_WB, 0);
    checkOutput({ph, "RfWb"}, {rf_we_WB, rf_dst_WB}, 0);
    checkOutput({ph, "Hlt"}, hlt_WB, 0);
    checkOutput({ph, "Err"}, mem_err, 0);
  endtask

  // Memory responder: acks each access after the latency chosen at issue.
  initial begin : responder
    bit active = 0, ended = 0;
    int k = 0, curLat = 1;
    dmem_ack = 1'b0;
    dmem_rdata = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !dmem_req) begin
        active = 0; ended = 0;
        dmem_ack = rst_n && ($urandom_range(0, 5) == 0);
        dmem_rdata = 16'($urandom);
      end else begin
        if (!active || ended) begin
          active = 1; k = 1;
          curLat = (latQ.size() > 0) ? latQ.pop_front() : 1;
        end else begin
          k++;
        end
        dmem_ack = (k == curLat);
        dmem_rdata = memWord(dmem_addr);
        ended = dmem_ack || (k == TIMEOUT + 1);
        if (dmem_ack) begin
          prevAckAddr = lastAckAddr;
          lastAckAddr = dmem_addr;
        end
      end
    end
  end

  // Retirement scoreboard and stall-cycle counter.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall) obsStall++;
      if (rf_we_WB || hlt_WB) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedRetire", {rf_we_WB, hlt_WB}, 0);
        end else begin
          monEntry = expQ.pop_front();
          checkOutput("retireRfWe", rf_we_WB, monEntry.rfWe);
          checkOutput("retireHlt", hlt_WB, monEntry.hlt);
          if (monEntry.rfWe) begin
            checkOutput("retireDst", rf_dst_WB, monEntry.dst);
            checkOutput("retireData", wb_data_WB, monEntry.data);
          end
        end
      end
    end
  end

  initial begin : guard
    #200000;
    $display("[TB] FAIL globalTimeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin : main
    int s0;
    rst_n = 1'b0;
    ex_valid = 0; ex_mem_re = 0; ex_mem_we = 0; ex_rf_we = 0; ex_hlt = 0;
    ex_dst = 0; ex_sdata = 0; ex_rf_dst = 0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;

    s0 = obsStall;
    applyStimulus(1, 0, 0, 1, 4'd3, 16'h1234, 16'h0, 0, 1);
    @(negedge clk);
    checkOutput("aluFwdMem", alu_result_MEM_WB, 16'h1234);
    checkOutput("aluRfMem", {rf_we_MEM, rf_dst_MEM}, {1'b1, 4'd3});
    @(negedge clk);
    checkOutput("aluWbData", wb_data_WB, 16'h1234);
    checkOutput("aluRfWb", {rf_we_WB, rf_dst_WB}, {1'b1, 4'd3});
    #1 checkOutput("aluStall", obsStall - s0, 0);

    s0 = obsStall;
    applyStimulus(1, 1, 0, 1, 4'd5, 16'h0040, 16'h0, 0, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("loadReq", dmem_req, 1);
      checkOutput("loadAddr", dmem_addr, 16'h0040);
      checkOutput("loadBubble", rf_we_WB, 0);
    end
    @(negedge clk);
    checkOutput("loadWbData", wb_data_WB, 16'hBEEF);
    checkOutput("loadRfWb", rf_we_WB, 1);
    #1 checkOutput("loadStall", obsStall - s0, 2);

    s0 = obsStall;
    applyStimulus(1, 0, 1, 0, 4'd0, 16'h0010, 16'hA5A5, 0, 1);
    @(negedge clk);
    checkOutput("storeReq", {dmem_req, dmem_we}, 2'b11);
    checkOutput("storeAddr", dmem_addr, 16'h0010);
    checkOutput("storeWdata", dmem_wdata, 16'hA5A5);
    @(negedge clk);
    checkOutput("storeRfWb", rf_we_WB, 0);
    #1 checkOutput("storeStall", obsStall - s0, 0);

    applyStimulus(1, 1, 0, 1, 4'd6, 16'h0002, 16'h0, 0, 1);
    applyStimulus(1, 1, 0, 1, 4'd7, 16'h0003, 16'h0, 0, 1);
    @(negedge clk);
    checkOutput("b2bReq", dmem_req, 1);
    checkOutput("b2bAddr", dmem_addr, 16'h0003);
    #1;
    checkOutput("b2bAckOrder", {prevAckAddr, lastAckAddr}, {16'h0002, 16'h0003});

    s0 = obsStall;
    applyStimulus(1, 1, 0, 1, 4'd8, 16'h0050, 16'h0, 0, 99);
    repeat (6) @(negedge clk);
    #1;
    checkOutput("toStall", obsStall - s0, TIMEOUT);
    checkOutput("toErr", mem_err, 1);
    checkOutput("toIdle", {stall, dmem_req}, 2'b00);

    for (int n = 0; n < 200; n++) begin
      int kind;
      logic v, re, we, rw, h;
      v = ($urandom_range(0, 99) < 88);
      kind = $urandom_range(0, 19);
      re = (kind >= 10 && kind <= 14);
      we = (kind >= 15 && kind <= 17);
      h  = (kind == 18);
      rw = we ? 1'($urandom_range(0, 1)) : (kind < 15);
      applyStimulus(v, re, we, rw, 4'($urandom), 16'($urandom), 16'($urandom), h,
                    latTab[$urandom_range(0, 6)]);
    end
    repeat (12) @(negedge clk);
    #1;
    checkOutput("drainQueue", expQ.size(), 0);
    checkOutput("totalStall", obsStall, expStall);
    checkOutput("stickyErr", mem_err, expErr);

    applyStimulus(1, 1, 0, 1, 4'd9, 16'h0077, 16'h0, 0, 99);
    @(negedge clk);
    checkOutput("preResetReq", dmem_req, 1);
    #2 rst_n = 1'b0;
    #1 checkOutput("asyncReqDrop", dmem_req, 0);
    latQ.delete();
    expQ.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkResetState("postReset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
